// File: rtl/hazard_ctrl_arbiter.sv
// hazard_ctrl_arbiter
//   Arbitrates NCH hazard-detection channels onto a single control word.
//   The highest-index channel has priority. A granted word is held for
//   hold_len[w]+1 cycles; with PREEMPT set, a higher-index request may take
//   over an active hold.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req        per-channel request, bit i = channel i
//   ctrl_in    per-channel control word, channel i at [i*CW +: CW]
//   hold_len   per-channel extra hold cycles, channel i at [i*CNTW +: CNTW]
//   idle_ctrl  control word driven when no channel owns the output
//   strict     1 = one-hot mode (multi-requests rejected), 0 = priority mode
//   sig_out    registered selected control word
//   grant      registered one-hot grant of current owner
//   busy       registered, high while a hold is in progress
//   conflict   registered one-cycle pulse on a rejected strict multi-request
module hazard_ctrl_arbiter #(
   parameter int NCH     = 3,
   parameter int CW      = 3,
   parameter int CNTW    = 4,
   parameter int PREEMPT = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NCH-1:0]      req,
   input  logic [NCH*CW-1:0]   ctrl_in,
   input  logic [NCH*CNTW-1:0] hold_len,
   input  logic [CW-1:0]       idle_ctrl,
   input  logic                strict,
   output logic [CW-1:0]       sig_out,
   output logic [NCH-1:0]      grant,
   output logic                busy,
   output logic                conflict
);

   localparam int OW = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic {IDLE, HOLD} state_t;

   state_t          state_q, state_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [OW-1:0]   owner_q, owner_d;
   logic [CW-1:0]   sig_d;
   logic [NCH-1:0]  grant_d;
   logic            busy_d, conflict_d;

   logic            arb;
   logic            top_any, multi, pre_any;
   logic [OW-1:0]   top_idx, pre_idx;
   logic            win_valid;
   logic [OW-1:0]   win_idx;
   logic [CW-1:0]   win_ctrl;
   logic [CNTW-1:0] win_hold;

   // Ascending scan: the last set bit seen is the highest index. pre_* only
   // considers channels above the current owner (preemption candidates).
   always_comb begin : scan
      top_any = 1'b0;
      multi   = 1'b0;
      pre_any = 1'b0;
      top_idx = '0;
      pre_idx = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (req[i]) begin
            multi   = multi | top_any;
            top_any = 1'b1;
            top_idx = OW'(i);
            if (OW'(i) > owner_q) begin
               pre_any = 1'b1;
               pre_idx = OW'(i);
            end
         end
      end
   end

   // Winner selection. An arbitration cycle is IDLE or the last hold cycle;
   // otherwise only preemption by a higher-index channel can win, and strict
   // mode does not apply.
   always_comb begin : decide
      arb        = (state_q == IDLE) || (cnt_q == '0);
      win_valid  = 1'b0;
      win_idx    = '0;
      conflict_d = 1'b0;
      if (arb) begin
         win_idx = top_idx;
         if (strict) begin
            win_valid  = top_any & ~multi;
            conflict_d = multi;
         end else begin
            win_valid = top_any;
         end
      end else if (PREEMPT != 0) begin
         win_valid = pre_any;
         win_idx   = pre_idx;
      end
   end

   always_comb begin : next
      state_d  = state_q;
      cnt_d    = cnt_q;
      owner_d  = owner_q;
      sig_d    = sig_out;
      grant_d  = grant;
      busy_d   = busy;
      win_ctrl = '0;
      win_hold = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (OW'(i) == win_idx) begin
            win_ctrl = ctrl_in[i*CW +: CW];
            win_hold = hold_len[i*CNTW +: CNTW];
         end
      end
      if (win_valid) begin
         sig_d   = win_ctrl;
         owner_d = win_idx;
         cnt_d   = win_hold;
         for (int unsigned i = 0; i < NCH; i++) begin
            grant_d[i] = (OW'(i) == win_idx);
         end
         if (win_hold == '0) begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end else begin
            state_d = HOLD;
            busy_d  = 1'b1;
         end
      end else if (arb) begin
         sig_d   = idle_ctrl;
         grant_d = '0;
         busy_d  = 1'b0;
         cnt_d   = '0;
         state_d = IDLE;
      end else begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         owner_q  <= '0;
         sig_out  <= '0;
         grant    <= '0;
         busy     <= 1'b0;
         conflict <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         owner_q  <= owner_d;
         sig_out  <= sig_d;
         grant    <= grant_d;
         busy     <= busy_d;
         conflict <= conflict_d;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl_arbiter.sv
// Testbench for hazard_ctrl_arbiter (NCH=3, CW=3, CNTW=4, PREEMPT=1).
// A cycle-level model tracks the expected outputs in terms of grant
// periods; literal expectations pin the directed scenarios.
module tb_hazard_ctrl_arbiter;

   logic        clk;
   logic        rst;
   logic [2:0]  req;
   logic [8:0]  ctrl_in;
   logic [11:0] hold_len;
   logic [2:0]  idle_ctrl;
   logic        strict;
   logic [2:0]  sig_out;
   logic [2:0]  grant;
   logic        busy;
   logic        conflict;

   logic [2:0] c0, c1, c2;
   logic [3:0] h0, h1, h2;
   assign ctrl_in  = {c2, c1, c0};
   assign hold_len = {h2, h1, h0};

   hazard_ctrl_arbiter #(
      .NCH(3),
      .CW(3),
      .CNTW(4),
      .PREEMPT(1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req(req),
      .ctrl_in(ctrl_in),
      .hold_len(hold_len),
      .idle_ctrl(idle_ctrl),
      .strict(strict),
      .sig_out(sig_out),
      .grant(grant),
      .busy(busy),
      .conflict(conflict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- model ----------------
   // m_left: how many more cycles the current grant stays on the output
   // after the present one, absent preemption. 0 means the next edge
   // arbitrates freely.
   logic [2:0] m_sig, m_grant;
   logic       m_busy, m_conf;
   int         m_owner, m_left;
   int         m_win, m_n;
   logic       m_free;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_sig = 3'b000; m_grant = 3'b000; m_busy = 1'b0; m_conf = 1'b0;
         m_owner = 0; m_left = 0;
      end else begin
         m_conf = 1'b0;
         m_win  = -1;
         m_free = (m_left == 0);
         if (m_free) begin
            m_n = $countones(req);
            if (!(strict && m_n > 1)) begin
               for (int i = 0; i < 3; i++) if (req[i]) m_win = i;
            end
            m_conf = strict && (m_n > 1);
         end else begin
            m_left = m_left - 1;
            for (int i = 0; i < 3; i++) if (req[i] && i > m_owner) m_win = i;
         end
         if (m_win >= 0) begin
            m_sig   = ctrl_in[m_win*3 +: 3];
            m_grant = 3'(1 << m_win);
            m_owner = m_win;
            m_left  = int'(hold_len[m_win*4 +: 4]);
            m_busy  = (m_left > 0);
         end else if (m_free) begin
            m_sig = idle_ctrl; m_grant = 3'b000; m_busy = 1'b0;
         end
      end
   end

   // ---------------- checker ----------------
   int         total = 0;
   int         bad   = 0;
   logic       mdl_on;
   logic       probe;
   string      lit_name;
   logic [2:0] lit_sig, lit_grant;
   logic       lit_busy, lit_conf;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk or posedge probe) begin
      if (probe) begin
         chk({lit_name, ".sig"},      32'(sig_out),  32'(lit_sig));
         chk({lit_name, ".grant"},    32'(grant),    32'(lit_grant));
         chk({lit_name, ".busy"},     32'(busy),     32'(lit_busy));
         chk({lit_name, ".conflict"}, 32'(conflict), 32'(lit_conf));
      end else if (mdl_on) begin
         chk("mdl.sig",      32'(sig_out),  32'(m_sig));
         chk("mdl.grant",    32'(grant),    32'(m_grant));
         chk("mdl.busy",     32'(busy),     32'(m_busy));
         chk("mdl.conflict", 32'(conflict), 32'(m_conf));
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(negedge clk);
   endtask

   task automatic lit(input string nm, input logic [2:0] s, input logic [2:0] g,
                      input logic b, input logic c);
      lit_name = nm; lit_sig = s; lit_grant = g; lit_busy = b; lit_conf = c;
      #1 probe = 1'b1;
      #1 probe = 1'b0;
   endtask

   logic [2:0] req_tab [8] = '{3'b001, 3'b010, 3'b111, 3'b000,
                               3'b100, 3'b011, 3'b110, 3'b101};

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; req = 3'b000; strict = 1'b0; idle_ctrl = 3'b010;
      c0 = 3'b000; c1 = 3'b000; c2 = 3'b000;
      h0 = 4'd0; h1 = 4'd0; h2 = 4'd0;
      probe = 1'b0; mdl_on = 1'b0; lit_name = "";
      lit_sig = 3'b000; lit_grant = 3'b000; lit_busy = 1'b0; lit_conf = 1'b0;

      #2 lit("reset", 3'b000, 3'b000, 1'b0, 1'b0);
      mdl_on = 1'b1;
      step(); rst = 1'b0;
      step(); lit("idle", 3'b010, 3'b000, 1'b0, 1'b0);

      // single grant, hold_len 2 -> three cycles
      c0 = 3'b101; h0 = 4'd2; req = 3'b001;
      step(); req = 3'b000;
      lit("hold_c1", 3'b101, 3'b001, 1'b1, 1'b0);
      step(); lit("hold_c2", 3'b101, 3'b001, 1'b1, 1'b0);
      step(); lit("hold_c3", 3'b101, 3'b001, 1'b1, 1'b0);
      step(); lit("hold_end", 3'b010, 3'b000, 1'b0, 1'b0);

      // priority mode
      c1 = 3'b110; h1 = 4'd0; req = 3'b011;
      step(); lit("prio", 3'b110, 3'b010, 1'b0, 1'b0);

      // strict conflict
      strict = 1'b1; req = 3'b110;
      step(); lit("strict_conf", 3'b010, 3'b000, 1'b0, 1'b1);
      req = 3'b000;
      step(); lit("conf_clear", 3'b010, 3'b000, 1'b0, 1'b0);
      strict = 1'b0;

      // preemption during hold, then back-to-back grant of the lower channel
      c0 = 3'b011; h0 = 4'd5; c1 = 3'b100; h1 = 4'd0; c2 = 3'b111; h2 = 4'd3;
      req = 3'b001;
      step(); req = 3'b000;
      lit("pre_h1", 3'b011, 3'b001, 1'b1, 1'b0);
      step(); lit("pre_h2", 3'b011, 3'b001, 1'b1, 1'b0);
      step(); lit("pre_h3", 3'b011, 3'b001, 1'b1, 1'b0);
      req = 3'b110;
      step(); lit("preempt", 3'b111, 3'b100, 1'b1, 1'b0);
      req = 3'b010;
      step(); lit("pre_ignore", 3'b111, 3'b100, 1'b1, 1'b0);
      step(); step(); lit("pre_last", 3'b111, 3'b100, 1'b1, 1'b0);
      step(); lit("b2b", 3'b100, 3'b010, 1'b0, 1'b0);
      req = 3'b000;
      step();

      // continuous zero-length grants
      c0 = 3'b001; h0 = 4'd0; req = 3'b001;
      for (int k = 0; k < 6; k++) begin
         step(); lit("stream", 3'b001, 3'b001, 1'b0, 1'b0);
      end
      req = 3'b000;
      step(); lit("stream_end", 3'b010, 3'b000, 1'b0, 1'b0);

      // all-ones hold length -> 16 cycles
      c0 = 3'b101; h0 = 4'hF; req = 3'b001;
      step(); req = 3'b000;
      lit("max_hold", 3'b101, 3'b001, 1'b1, 1'b0);
      for (int k = 0; k < 15; k++) begin
         step(); lit("max_hold", 3'b101, 3'b001, 1'b1, 1'b0);
      end
      step(); lit("max_end", 3'b010, 3'b000, 1'b0, 1'b0);

      // asynchronous reset in the middle of a hold
      c1 = 3'b011; h1 = 4'd5; req = 3'b010;
      step(); req = 3'b000;
      lit("pre_rst", 3'b011, 3'b010, 1'b1, 1'b0);
      #1 rst = 1'b1;
      lit("rst_async", 3'b000, 3'b000, 1'b0, 1'b0);
      step(); lit("rst_held", 3'b000, 3'b000, 1'b0, 1'b0);
      c2 = 3'b110; h2 = 4'd0; req = 3'b100; rst = 1'b0;
      step(); lit("after_rst", 3'b110, 3'b100, 1'b0, 1'b0);
      req = 3'b000;

      // mixed vectors, checked against the model only
      for (int k = 0; k < 32; k++) begin
         req    = req_tab[k % 8];
         strict = ((k / 8) % 2) == 1;
         h0 = 4'(k % 3); h1 = 4'((k + 1) % 4); h2 = 4'(k % 2);
         c0 = 3'(k); c1 = 3'(k + 3); c2 = 3'(~k);
         step();
      end
      req = 3'b000;
      step(); step(); step(); step(); step(); step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
